// File: rtl/packet_rcvr.sv
// Serial packet receiver: hunts for an 8-bit header on data_in (MSB first), then
// captures the following 8-bit body into data_out and flags it with ready/overrun.
module packet_rcvr #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       reading,
  output logic       ready,
  output logic       overrun,
  output logic [7:0] data_out
);

  typedef enum logic {
    SEARCH = 1'b0,
    BODY   = 1'b1
  } state_t;

  state_t     state, state_d;
  logic [7:0] header_sr, header_sr_d;
  logic [7:0] body_sr, body_sr_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic       byte_done;

  // Handshake: ready=1 means data_out holds an unread byte; a one-cycle reading
  // pulse consumes it. A byte completing on the same edge as reading wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      header_sr <= 8'h00;
      body_sr   <= 8'h00;
      bit_cnt   <= 3'd0;
    end else begin
      state     <= state_d;
      header_sr <= header_sr_d;
      body_sr   <= body_sr_d;
      bit_cnt   <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    header_sr_d = header_sr;
    body_sr_d   = body_sr;
    bit_cnt_d   = bit_cnt;
    byte_done   = 1'b0;
    case (state)
      SEARCH: begin
        header_sr_d = {header_sr[6:0], data_in};
        if (header_sr_d == HEADER) begin
          state_d   = BODY;
          bit_cnt_d = 3'd0;
        end
      end
      BODY: begin
        body_sr_d = {body_sr[6:0], data_in};
        bit_cnt_d = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done   = 1'b1;
          state_d     = SEARCH;
          header_sr_d = 8'h00;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // A completing byte overruns only if the previous one is still unread and not
  // being read on this very edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready    <= 1'b0;
      overrun  <= 1'b0;
      data_out <= 8'h00;
    end else if (byte_done) begin
      data_out <= body_sr_d;
      ready    <= 1'b1;
      overrun  <= reading ? 1'b0 : (overrun | ready);
    end else if (reading) begin
      ready    <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packet_rcvr.sv
// Directed bench for packet_rcvr: drivers push {overrun, byte} expectations and a
// negedge monitor pops and compares each time the DUT presents a new byte.
module tb_packet_rcvr;

  logic       clock;
  logic       reset;
  logic       data_in;
  logic       reading;
  logic       ready;
  logic       overrun;
  logic [7:0] data_out;

  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       ready_q = 1'b0;
  logic       overrun_q = 1'b0;
  logic [7:0] data_q = 8'h00;
  logic       stream_on = 1'b0;
  string      rx_str = "";

  packet_rcvr #(.HEADER(8'hA5)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .reading  (reading),
    .ready    (ready),
    .overrun  (overrun),
    .data_out (data_out)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: called at posedge+1, return at posedge+1
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_read();
    reading = 1'b1;
    @(posedge clock);
    #1;
    reading = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] body, input logic ovr_exp, input logic read_last);
    exp_q.push_back({ovr_exp, body});
    send_byte(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      reading = read_last && (i == 0);
      send_bit(body[i]);
    end
    reading = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [8:0] exp;
    if (!reset && ((ready && !ready_q) || (overrun && !overrun_q) ||
                   (ready && ready_q && data_out != data_q))) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_byte: got data %0h ovr %0b with nothing expected", data_out, overrun);
      end else begin
        exp = exp_q.pop_front();
        if ({overrun, data_out} !== exp) begin
          n_errors++;
          $display("FAIL byte: got ovr %0b data %0h expected ovr %0b data %0h",
                   overrun, data_out, exp[8], exp[7:0]);
        end
        if (stream_on) rx_str = {rx_str, string'(data_out)};
      end
    end
    ready_q   = ready;
    overrun_q = overrun;
    data_q    = data_out;
  end

  string msg = "I Love Verilog";
  int    rd_dly[14] = '{0, 3, 14, 1, 7, 2, 10, 5, 0, 12, 4, 8, 6, 9};
  int    gap[14]    = '{0, 8, 1, 5, 2, 7, 3, 0, 6, 4, 8, 1, 2, 3};

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;
    reading = 1'b0;
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_data", 32'(data_out), 32'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // idle line
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b0);
      check("idle_outputs", {22'd0, ready, overrun, data_out}, 32'd0);
    end

    // single packet, exact latency
    exp_q.push_back({1'b0, 8'h49});
    send_byte(8'hA5);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h49 >> i));
    check("ready_before_last_bit", 32'(ready), 32'd0);
    send_bit(1'b1);
    check("ready_on_last_bit", 32'(ready), 32'd1);
    pulse_read();
    check("ready_after_read", 32'(ready), 32'd0);
    check("data_kept_after_read", 32'(data_out), 32'h49);

    // message stream
    stream_on = 1'b1;
    for (int k = 0; k < msg.len(); k++) begin
      send_packet(msg[k], 1'b0, 1'b0);
      idle(rd_dly[k]);
      pulse_read();
      idle(gap[k]);
    end
    stream_on = 1'b0;
    n_checks++;
    if (rx_str != msg) begin
      n_errors++;
      $display("FAIL stream_string: got \"%s\" expected \"%s\"", rx_str, msg);
    end

    // overrun
    send_packet(8'h41, 1'b0, 1'b0);
    send_packet(8'h42, 1'b1, 1'b0);
    check("ovr_ready", 32'(ready), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_data", 32'(data_out), 32'h42);
    pulse_read();
    check("ovr_cleared_ready", 32'(ready), 32'd0);
    check("ovr_cleared_flag", 32'(overrun), 32'd0);

    // read on the completing edge
    send_packet(8'h41, 1'b0, 1'b0);
    send_packet(8'h42, 1'b0, 1'b1);
    check("simul_ready", 32'(ready), 32'd1);
    check("simul_overrun", 32'(overrun), 32'd0);
    check("simul_data", 32'(data_out), 32'h42);
    pulse_read();

    // false header
    idle(1);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    send_byte(8'hA4);
    send_byte(8'h5A);
    idle(4);
    check("false_header_ready", 32'(ready), 32'd0);

    // async reset in the middle of a body, with an unread byte pending
    send_packet(8'h3C, 1'b0, 1'b0);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_ready", 32'(ready), 32'd0);
    check("async_rst_overrun", 32'(overrun), 32'd0);
    check("async_rst_data", 32'(data_out), 32'h00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_packet(8'h7E, 1'b0, 1'b0);
    check("post_reset_data", 32'(data_out), 32'h7E);
    pulse_read();
    idle(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_expected: got %0d bytes never presented expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
